bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of bus hosts (1..8).
REQ-002 SHALL have parameter NrDevices, default 3, number of bus devices (1..16).
REQ-003 SHALL have parameter DataWidth, default 32, data bits.
REQ-004 SHALL have parameter AddressWidth, default 32, address bits.
REQ-005 SHALL have parameter TimeoutCycles, default 255, response timeout limit (used only under BUS_ARBITER_TIMEOUT_EN).
REQ-006 SHALL have port clk_i  input  1  the single clock.
REQ-007 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have ports host_req_i, host_we_i  input  1 per host (unpacked [NrHosts])  request and write enable.
REQ-009 SHALL have ports host_addr_i  input  AddressWidth; host_be_i  input  DataWidth/8; host_wdata_i  input  DataWidth; all per host.
REQ-010 SHALL have ports host_gnt_o, host_rvalid_o, host_err_o  output  1 per host; host_rdata_o  output  DataWidth per host.
REQ-011 SHALL have ports device_req_o, device_we_o  output  1 per device; device_addr_o, device_be_o, device_wdata_o  output  matching host widths, per device.
REQ-012 SHALL have ports device_rvalid_i, device_err_i  input  1 per device; device_rdata_i  input  DataWidth per device.
REQ-013 SHALL have ports cfg_device_addr_base, cfg_device_addr_mask  input  AddressWidth per device  address map.

Function
REQ-014 SHALL decode device d when (addr & mask[d]) == base[d]; on multiple matches, lowest index wins.
REQ-015 SHALL arbitrate requesting hosts round-robin: search starts at last-granted host + 1, wrapping at NrHosts-1 to 0; after reset, the pointer starts at host 0.
REQ-016 SHALL assert host_gnt_o for exactly one host per cycle, combinationally, only when state is IDLE or the outstanding response completes that cycle.
REQ-017 SHALL, on grant, drive device_req_o, addr, we, be and wdata of the decoded device for that cycle only; all other devices see req=0.
REQ-018 SHALL implement FSM IDLE -> WAIT on grant; WAIT -> IDLE on response with no new grant; WAIT -> WAIT on response plus same-cycle new grant.
REQ-019 SHALL register the granted host index and device index (or an unmapped flag) at grant.
REQ-020 SHALL, in WAIT, forward device_rvalid_i, device_rdata_i and device_err_i of the registered device to the registered host only; other hosts see rvalid=0.
REQ-021 SHALL answer an unmapped request exactly one cycle after grant with rvalid=1, err=1, rdata=0, and SHALL NOT assert any device_req_o.
REQ-022 SHALL drop device_rvalid_i from any device not currently outstanding.
REQ-023 SHALL sustain one transaction per cycle when devices respond in the cycle after request.
REQ-024 SHALL drive host_rdata_o to 0 whenever host_rvalid_o is 0.

Reset
REQ-025 SHALL, while rst_ni=0: FSM=IDLE, RR pointer=0, outstanding indices=0, timeout counter=0, and all gnt, rvalid, err, device_req outputs=0.
REQ-026 SHALL abandon an in-flight transaction on mid-operation reset and drop any later rvalid for it.

Configuration
REQ-027 SHALL compile the response timeout in only when macro BUS_ARBITER_TIMEOUT_EN is defined.
REQ-028 SHALL, with BUS_ARBITER_TIMEOUT_EN, count WAIT cycles from 1; if count reaches TimeoutCycles without rvalid, respond rvalid=1, err=1, rdata=0 to the host and return to IDLE (a new grant is allowed that cycle).
REQ-029 SHALL, without BUS_ARBITER_TIMEOUT_EN, contain no counter and wait in WAIT indefinitely.

Structure
REQ-030 SHALL place the FSM state enum and the unmapped-device index constant in shared package bus_arbiter_pkg.
REQ-031 SHALL implement round-robin selection in sub-module bus_rr_arb (request vector in; one-hot grant and pointer update out).

Verification
REQ-032 SHALL cover: hosts 0 and 1 request RAM (0x100000) on the same cycle, repeated -> grants alternate 0,1,0,1; each rvalid reaches the matching host.
REQ-033 SHALL cover: host 1 reads 0x00000004 (unmapped) -> no device_req; next cycle host 1 sees rvalid=1, err=1, rdata=0.
REQ-034 SHALL cover: back-to-back host 0 writes to 0x20000 then 0x30000 -> device_req[1] then device_req[2] on consecutive cycles, two rvalids on consecutive cycles.
REQ-035 SHALL cover: with BUS_ARBITER_TIMEOUT_EN and TimeoutCycles=4, the device never responds -> err=1 rvalid on cycle 4 after grant; a late device rvalid is dropped.
REQ-036 SHALL cover: rst_ni pulled low during WAIT -> all outputs 0 the same cycle; after release, the first grant goes to the lowest requesting host.
REQ-037 SHALL cover: overlapping maps where base 0x20000/mask ~0x3FF match devices 1 and 2 -> device 1 selected.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM state, index widths and the unmapped-device marker.
package bus_arbiter_pkg;
    typedef enum logic {ST_IDLE, ST_WAIT} state_e;
    localparam int HOST_IDX_W = 3;
    localparam int DEV_IDX_W = 5;
    localparam logic [DEV_IDX_W-1:0] DEV_UNMAPPED = '1;
endpackage

// File: rtl/bus_rr_arb.sv
// bus_rr_arb: round-robin pick among requesting hosts, searching from ptr upward with wrap.
module bus_rr_arb
    import bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          req,
    input  logic [HOST_IDX_W-1:0] ptr,
    output logic [N-1:0]          gnt,
    output logic [HOST_IDX_W-1:0] idx,
    output logic [HOST_IDX_W-1:0] ptr_nxt
);
    logic found;
    always_comb begin
        found = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            for (int h = 0; h < N; h++) begin
                if (!found && req[h] && h == (int'(ptr) + i) % N) begin
                    found = 1'b1;
                    gnt[h] = 1'b1;
                    idx = HOST_IDX_W'(h);
                end
            end
        end
        ptr_nxt = (int'(idx) == N - 1) ? '0 : idx + HOST_IDX_W'(1);
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: multi-host to multi-device bus with address decode and round-robin arbitration.
// Optional response timeout is compiled in with BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NrHosts = 2,
    parameter int NrDevices = 3,
    parameter int DataWidth = 32,
    parameter int AddressWidth = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    host_req_i           [NrHosts],
    input  logic                    host_we_i            [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
    output logic                    host_gnt_o           [NrHosts],
    output logic                    host_rvalid_o        [NrHosts],
    output logic                    host_err_o           [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
    output logic                    device_req_o         [NrDevices],
    output logic                    device_we_o          [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
    input  logic                    device_rvalid_i      [NrDevices],
    input  logic                    device_err_i         [NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);
    state_e state;
    logic [NrHosts-1:0] req_vec, arb_gnt;
    logic [HOST_IDX_W-1:0] rr_ptr, arb_idx, ptr_nxt, host_r;
    logic [DEV_IDX_W-1:0] dev_sel, dev_r;
    logic [AddressWidth-1:0] sel_addr;
    logic [DataWidth/8-1:0] sel_be;
    logic [DataWidth-1:0] sel_wdata, dev_rdata;
    logic sel_we, dev_rv, dev_err, unmapped_r, to_hit, resp_done, can_grant, grant, synth;

    bus_rr_arb #(.N(NrHosts)) u_rr (
        .req(req_vec),
        .ptr(rr_ptr),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .ptr_nxt(ptr_nxt)
    );

    assign unmapped_r = dev_r == DEV_UNMAPPED;
    assign resp_done = state == ST_WAIT && (unmapped_r || dev_rv || to_hit);
    // Grants are suppressed combinationally while reset is held.
    assign can_grant = rst_ni && (state == ST_IDLE || resp_done);
    assign grant = can_grant && |req_vec;
    assign synth = unmapped_r || !dev_rv;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [31:0] to_cnt;
    assign to_hit = state == ST_WAIT && to_cnt >= 32'(TimeoutCycles);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) to_cnt <= '0;
        else if (grant) to_cnt <= 32'd1;
        else to_cnt <= (state == ST_WAIT && !resp_done) ? to_cnt + 32'd1 : '0;
    end
`else
    assign to_hit = TimeoutCycles < 0;
`endif

    always_comb begin
        sel_addr = '0;
        sel_be = '0;
        sel_wdata = '0;
        sel_we = 1'b0;
        for (int h = 0; h < NrHosts; h++) begin
            req_vec[h] = host_req_i[h];
            if (arb_gnt[h]) begin
                sel_addr = host_addr_i[h];
                sel_be = host_be_i[h];
                sel_wdata = host_wdata_i[h];
                sel_we = host_we_i[h];
            end
        end
        // Descending scan so the lowest matching index wins.
        dev_sel = DEV_UNMAPPED;
        for (int d = NrDevices - 1; d >= 0; d--)
            if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) dev_sel = DEV_IDX_W'(d);
        dev_rv = 1'b0;
        dev_err = 1'b0;
        dev_rdata = '0;
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d] = grant && dev_sel == DEV_IDX_W'(d);
            device_we_o[d] = sel_we;
            device_addr_o[d] = sel_addr;
            device_be_o[d] = sel_be;
            device_wdata_o[d] = sel_wdata;
            if (dev_r == DEV_IDX_W'(d)) begin
                dev_rv = device_rvalid_i[d];
                dev_err = device_err_i[d];
                dev_rdata = device_rdata_i[d];
            end
        end
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = grant && arb_gnt[h];
            host_rvalid_o[h] = resp_done && host_r == HOST_IDX_W'(h);
            host_err_o[h] = host_rvalid_o[h] && (synth || dev_err);
            host_rdata_o[h] = (host_rvalid_o[h] && !synth) ? dev_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            rr_ptr <= '0;
            host_r <= '0;
            dev_r <= '0;
        end else if (grant) begin
            state <= ST_WAIT;
            rr_ptr <= ptr_nxt;
            host_r <= arb_idx;
            dev_r <= dev_sel;
        end else if (resp_done) begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with grant/response scoreboard queues checked by a negedge monitor.
module tb_bus_arbiter;
    localparam int NH = 2, ND = 3, DW = 32, AW = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    logic host_req [NH], host_we [NH], host_gnt [NH], host_rvalid [NH], host_err [NH];
    logic [AW-1:0] host_addr [NH];
    logic [DW/8-1:0] host_be [NH];
    logic [DW-1:0] host_wdata [NH], host_rdata [NH];
    logic dev_req [ND], dev_we [ND], dev_rvalid [ND], dev_err [ND];
    logic [AW-1:0] dev_addr [ND], base [ND], mask [ND];
    logic [DW/8-1:0] dev_be [ND];
    logic [DW-1:0] dev_wdata [ND], dev_rdata [ND];

    typedef struct {int cyc; int host; int dev; logic [31:0] addr; logic we; logic [31:0] wdata;} gnt_t;
    typedef struct {int cyc; int host; logic err; logic [31:0] data;} rsp_t;
    gnt_t gq[$];
    rsp_t rq[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic pend [ND], resp_en [ND], stray [ND];
    logic [AW-1:0] pend_addr [ND];

    bus_arbiter #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err), .host_rdata_o(host_rdata),
        .device_req_o(dev_req), .device_we_o(dev_we), .device_addr_o(dev_addr),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_err_i(dev_err), .device_rdata_i(dev_rdata),
        .cfg_device_addr_base(base), .cfg_device_addr_mask(mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int h, input logic r, input logic we, input logic [31:0] a, input logic [31:0] wd);
        host_req[h] = r;
        host_we[h] = we;
        host_addr[h] = a;
        host_wdata[h] = wd;
        host_be[h] = 4'hF;
    endtask

    task automatic push_g(input int c, input int h, input int d, input logic [31:0] a, input logic we, input logic [31:0] wd);
        gnt_t g;
        g.cyc = c; g.host = h; g.dev = d; g.addr = a; g.we = we; g.wdata = wd;
        gq.push_back(g);
    endtask

    task automatic push_r(input int c, input int h, input logic e, input logic [31:0] dat);
        rsp_t r;
        r.cyc = c; r.host = h; r.err = e; r.data = dat;
        rq.push_back(r);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Device model: answers one cycle after a request with {0xD0+dev, addr[23:0]}; err when addr ends in 0xE.
    initial forever begin
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            dev_rvalid[d] = (pend[d] && resp_en[d]) || stray[d];
            dev_rdata[d] = {8'hD0 + 8'(d), pend_addr[d][23:0]};
            dev_err[d] = pend_addr[d][3:0] == 4'hE;
        end
    end

    initial forever begin
        logic [NH-1:0] gv, rv;
        logic [ND-1:0] dv;
        gnt_t g;
        rsp_t r;
        @(negedge clk);
        gv = '0; rv = '0; dv = '0;
        for (int h = 0; h < NH; h++) begin
            gv[h] = host_gnt[h];
            rv[h] = host_rvalid[h];
            if (!host_rvalid[h]) chk("rdata_zero_when_idle", host_rdata[h], 32'h0);
        end
        for (int d = 0; d < ND; d++) begin
            dv[d] = dev_req[d];
            pend[d] = dev_req[d];
            if (dev_req[d]) pend_addr[d] = dev_addr[d];
        end
        if (gv != '0) begin
            if (gq.size() == 0) chk("unexpected_gnt", 32'(gv), 32'h0);
            else begin
                g = gq.pop_front();
                chk("gnt_cycle", cyc, g.cyc);
                chk("gnt_host", 32'(gv), 32'(1) << g.host);
                chk("dev_req", 32'(dv), g.dev >= 0 ? 32'(1) << g.dev : 32'h0);
                if (g.dev >= 0) begin
                    chk("dev_addr", dev_addr[g.dev], g.addr);
                    chk("dev_we", 32'(dev_we[g.dev]), 32'(g.we));
                    chk("dev_wdata", dev_wdata[g.dev], g.wdata);
                end
            end
        end else if (dv != '0) chk("dev_req_without_gnt", 32'(dv), 32'h0);
        if (rv != '0) begin
            if (rq.size() == 0) chk("unexpected_rvalid", 32'(rv), 32'h0);
            else begin
                r = rq.pop_front();
                chk("rsp_cycle", cyc, r.cyc);
                chk("rsp_host", 32'(rv), 32'(1) << r.host);
                chk("rsp_err", 32'(host_err[r.host]), 32'(r.err));
                chk("rsp_rdata", host_rdata[r.host], r.data);
            end
        end
    end

    initial begin
        int c;
        for (int h = 0; h < NH; h++) drive(h, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int d = 0; d < ND; d++) begin
            pend[d] = 1'b0; pend_addr[d] = '0; resp_en[d] = 1'b1; stray[d] = 1'b0;
            dev_rvalid[d] = 1'b0; dev_err[d] = 1'b0; dev_rdata[d] = '0;
        end
        base[0] = 32'h0010_0000; mask[0] = 32'hFFF0_0000;
        base[1] = 32'h0002_0000; mask[1] = 32'hFFFF_FC00;
        base[2] = 32'h0003_0000; mask[2] = 32'hFFFF_0000;
        drive(1, 1'b1, 1'b0, 32'h0010_0000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int h = 0; h < NH; h++) begin
            chk("reset_gnt", 32'(host_gnt[h]), 32'h0);
            chk("reset_rvalid", 32'(host_rvalid[h]), 32'h0);
        end
        for (int d = 0; d < ND; d++) chk("reset_dev_req", 32'(dev_req[d]), 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        step();
        // Both hosts hammer RAM: grants alternate 0,1,0,1.
        c = cyc;
        drive(0, 1'b1, 1'b0, 32'h0010_0010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0010_0020, 32'h0);
        for (int k = 0; k < 4; k++) begin
            push_g(c + k, k % 2, 0, k % 2 ? 32'h0010_0020 : 32'h0010_0010, 1'b0, 32'h0);
            push_r(c + k + 1, k % 2, 1'b0, k % 2 ? 32'hD010_0020 : 32'hD010_0010);
        end
        repeat (4) step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) step();
        // Unmapped read.
        c = cyc;
        drive(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
        push_g(c, 1, -1, 32'h0, 1'b0, 32'h0);
        push_r(c + 1, 1, 1'b1, 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        // Back-to-back writes to devices 1 and 2.
        c = cyc;
        drive(0, 1'b1, 1'b1, 32'h0002_0000, 32'h1111_1111);
        push_g(c, 0, 1, 32'h0002_0000, 1'b1, 32'h1111_1111);
        push_r(c + 1, 0, 1'b0, 32'hD102_0000);
        step();
        drive(0, 1'b1, 1'b1, 32'h0003_0000, 32'h2222_2222);
        push_g(c + 1, 0, 2, 32'h0003_0000, 1'b1, 32'h2222_2222);
        push_r(c + 2, 0, 1'b0, 32'hD203_0000);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        // Overlapping map: devices 1 and 2 both match, device 1 wins.
        base[2] = 32'h0002_0000; mask[2] = 32'hFFFF_FC00;
        c = cyc;
        drive(1, 1'b1, 1'b0, 32'h0002_0004, 32'h0);
        push_g(c, 1, 1, 32'h0002_0004, 1'b0, 32'h0);
        push_r(c + 1, 1, 1'b0, 32'hD102_0004);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        base[2] = 32'h0003_0000; mask[2] = 32'hFFFF_0000;
        // Device error is forwarded along with its data.
        c = cyc;
        drive(0, 1'b1, 1'b0, 32'h0003_000E, 32'h0);
        push_g(c, 0, 2, 32'h0003_000E, 1'b0, 32'h0);
        push_r(c + 1, 0, 1'b1, 32'hD203_000E);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        // Reset during WAIT, then pointer restarts at host 0.
        resp_en[0] = 1'b0;
        c = cyc;
        drive(0, 1'b1, 1'b0, 32'h0010_0000, 32'h0);
        push_g(c, 0, 0, 32'h0010_0000, 1'b0, 32'h0);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h0010_0040, 32'h0);
        step();
        rst_n = 1'b0;
        #1;
        for (int h = 0; h < NH; h++) begin
            chk("midrst_gnt", 32'(host_gnt[h]), 32'h0);
            chk("midrst_rvalid", 32'(host_rvalid[h]), 32'h0);
            chk("midrst_err", 32'(host_err[h]), 32'h0);
        end
        for (int d = 0; d < ND; d++) chk("midrst_dev_req", 32'(dev_req[d]), 32'h0);
        step();
        resp_en[0] = 1'b1;
        stray[1] = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0010_0080, 32'h0);
        rst_n = 1'b1;
        push_g(c + 3, 0, 0, 32'h0010_0080, 1'b0, 32'h0);
        push_r(c + 4, 0, 1'b0, 32'hD010_0080);
        step();
        stray[1] = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        push_g(c + 4, 1, 0, 32'h0010_0040, 1'b0, 32'h0);
        push_r(c + 5, 1, 1'b0, 32'hD010_0040);
        step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) step();
`ifdef BUS_ARBITER_TIMEOUT_EN
        // Silent device: timeout error on the 4th cycle after grant, late rvalid ignored.
        resp_en[2] = 1'b0;
        c = cyc;
        drive(0, 1'b1, 1'b0, 32'h0003_0000, 32'h0);
        push_g(c, 0, 2, 32'h0003_0000, 1'b0, 32'h0);
        push_r(c + 4, 0, 1'b1, 32'h0);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) step();
        #1;
        stray[2] = 1'b1;
        step();
        stray[2] = 1'b0;
        resp_en[2] = 1'b1;
        repeat (2) step();
`endif
        repeat (3) step();
        chk("gnt_queue_drained", gq.size(), 32'h0);
        chk("rsp_queue_drained", rq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
